// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bus: PC/adder return path, imem data, hazard/redirect controls and IF/ID outputs.
interface fetch_pc_stage_if;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;
    logic [31:0] instr_in;
    logic        stall;
    logic        dec_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misalign;

    modport master (
        output pc_out, if_id_pc, if_id_instr, if_id_valid, fetch_count, misalign,
        input  pc_plus4_in, instr_in, stall, dec_ready, branch_taken, branch_target
    );

    modport slave (
        input  pc_out, if_id_pc, if_id_instr, if_id_valid, fetch_count, misalign,
        output pc_plus4_in, instr_in, stall, dec_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, redirect/flush FSM and IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_TRAP_EN traps on misaligned redirect targets.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input logic              clk,
    input logic              rst,
    fetch_pc_stage_if.master bus
);
    localparam int unsigned      CNT_W      = 2;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_BUBBLES - 1);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, TRAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [31:0]      count_q, count_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;

    logic             advance_c;
    logic             redirect_c;
    logic             bad_target_c;
    logic [31:0]      target_c;

    assign advance_c  = !bus.stall && bus.dec_ready;
    assign redirect_c = bus.branch_taken && (state_q != TRAP);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bad_target_c = (bus.branch_target[1:0] != 2'b00);
    assign target_c     = bus.branch_target;
`else
    // Without the trap the low bits are dropped so the PC stays word aligned.
    logic [1:0] unused_target_lsb_c;
    assign unused_target_lsb_c = bus.branch_target[1:0];
    assign bad_target_c        = 1'b0;
    assign target_c            = {bus.branch_target[31:2], 2'b00};
`endif

    // Next-state and datapath: redirect wins over stall/dec_ready; FLUSH lasts FLUSH_BUBBLES cycles.
    always_comb begin
        state_d    = state_q;
        bub_d      = bub_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        mis_d      = mis_q;

        if (redirect_c) begin
            pc_d    = target_c;
            valid_d = 1'b0;
            if (bad_target_c) begin
                mis_d   = 1'b1;
                state_d = TRAP;
            end else begin
                bub_d   = CNT_RELOAD;
                state_d = FLUSH;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    valid_d = 1'b0;
                    state_d = RUN;
                end
                RUN: begin
                    if (advance_c) begin
                        if_pc_d    = pc_q;
                        if_instr_d = bus.instr_in;
                        valid_d    = 1'b1;
                        pc_d       = bus.pc_plus4_in;
                        count_d    = count_q + 32'd1;
                    end
                end
                FLUSH: begin
                    valid_d = 1'b0;
                    if (bub_q == '0) begin
                        state_d = RUN;
                    end else begin
                        bub_d = bub_q - 1'b1;
                    end
                end
                TRAP: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = BOOT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            bub_q      <= '0;
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
            count_q    <= 32'd0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bub_q      <= bub_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.if_id_pc    = if_pc_q;
    assign bus.if_id_instr = if_instr_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_count = count_q;
    assign bus.misalign    = mis_q;

endmodule
